// File: rtl/modsub.sv
// Modular subtractor: C = (A - B) mod q, q = {qH, zeros, 1'b1}.
// Up to three optional register stages (input, subtract, output) share a
// single advance enable so bubbles move with the data and nothing reorders.
// Build option: define MODSUB_RANGE_CHK_EN to add the err output, which
// flags transactions whose A or B is not below q.
module modsub #(
    parameter int LOGA   = 64,
    parameter int LOGB   = 64,
    parameter int LOGQ   = 64,
    parameter int LOGQH  = 47,
    parameter int FF_IN  = 1,
    parameter int FF_SUB = 1,
    parameter int FF_OUT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LOGA-1:0]  A,
    input  logic [LOGB-1:0]  B,
    input  logic [LOGQH-1:0] qH,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LOGQ-1:0]  C
`ifdef MODSUB_RANGE_CHK_EN
    ,
    output logic             err
`endif
);

    localparam int LAT = FF_IN + FF_SUB + FF_OUT;
    // difference width: one extra bit holds the borrow
    localparam int DW  = LOGQ + 1;
`ifdef MODSUB_RANGE_CHK_EN
    // range compare width covers every operand and q without truncation
    localparam int MW  = (LOGA > LOGB) ? LOGA : LOGB;
    localparam int CW  = ((MW > LOGQ) ? MW : LOGQ) + 1;
`endif

    typedef struct packed {
        logic [LOGA-1:0]  a;
        logic [LOGB-1:0]  b;
        logic [LOGQH-1:0] qh;
    } in_t;

    typedef struct packed {
        logic [DW-1:0]    d;
        logic [LOGQH-1:0] qh;
`ifdef MODSUB_RANGE_CHK_EN
        logic             err;
`endif
    } sub_t;

    typedef struct packed {
        logic [LOGQ-1:0]  c;
`ifdef MODSUB_RANGE_CHK_EN
        logic             err;
`endif
    } out_t;

    // q is rebuilt wherever needed from the qH carried with the transaction
    function automatic logic [LOGQ-1:0] mk_q(input logic [LOGQH-1:0] qh);
        return (LOGQ'(qh) << (LOGQ - LOGQH)) | LOGQ'(1);
    endfunction

    // vld_pipe[0] is the live input valid, vld_pipe[LAT] drives out_valid
    wire [LAT:0] vld_pipe;
    logic        stall;
    logic        adv;

    in_t  in_d,  s_in;
    sub_t sub_d, s_sub;
    out_t out_d, s_out;

    assign in_d        = {A, B, qH};
    assign vld_pipe[0] = in_valid;

    // valid shift register: only state that needs reset, holds on stall
    for (genvar i = 1; i <= LAT; i++) begin : g_vld
        logic v_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)   v_q <= 1'b0;
            else if (adv) v_q <= vld_pipe[i-1];
        end
        assign vld_pipe[i] = v_q;
    end

    if (FF_IN != 0) begin : g_ff_in
        // input operand register
        always_ff @(posedge clk) if (adv) s_in <= in_d;
    end else begin : g_no_in
        assign s_in = in_d;
    end

    // subtract at LOGQ+1 bits; the top bit is the borrow
    always_comb begin
        sub_d.d   = DW'(s_in.a) - DW'(s_in.b);
        sub_d.qh  = s_in.qh;
`ifdef MODSUB_RANGE_CHK_EN
        sub_d.err = (CW'(s_in.a) >= CW'(mk_q(s_in.qh))) ||
                    (CW'(s_in.b) >= CW'(mk_q(s_in.qh)));
`endif
    end

    if (FF_SUB != 0) begin : g_ff_sub
        // difference/borrow register
        always_ff @(posedge clk) if (adv) s_sub <= sub_d;
    end else begin : g_no_sub
        assign s_sub = sub_d;
    end

    // on borrow add q back; modulo 2^LOGQ wrap gives (D + q)[LOGQ-1:0]
    always_comb begin
        out_d.c   = s_sub.d[LOGQ] ? (s_sub.d[LOGQ-1:0] + mk_q(s_sub.qh))
                                  : s_sub.d[LOGQ-1:0];
`ifdef MODSUB_RANGE_CHK_EN
        out_d.err = s_sub.err;
`endif
    end

    if (FF_OUT != 0) begin : g_ff_out
        // result register
        always_ff @(posedge clk) if (adv) s_out <= out_d;
    end else begin : g_no_out
        assign s_out = out_d;
    end

    assign out_valid = vld_pipe[LAT];
    assign stall     = out_valid & ~out_ready;
    assign adv       = ~stall;
    // combinational build passes ready straight through, independent of in_valid
    assign in_ready  = (LAT == 0) ? out_ready : ~stall;
    assign C         = s_out.c;
`ifdef MODSUB_RANGE_CHK_EN
    // gated by valid so err reads 0 in reset and between transactions
    assign err       = out_valid & s_out.err;
`endif

endmodule

// File: tb/tb_modsub.sv
// Self-checking bench for modsub: directed vectors, stall, reset-in-flight
// and randomized traffic against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_modsub;

    localparam int LOGA   = 64;
    localparam int LOGB   = 64;
    localparam int LOGQ   = 64;
    localparam int LOGQH  = 47;
    localparam int FF_IN  = 1;
    localparam int FF_SUB = 1;
    localparam int FF_OUT = 1;
    localparam int LAT    = FF_IN + FF_SUB + FF_OUT;
    localparam logic [46:0] QH0 = 47'h400008C00000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready, out_valid;
    logic [63:0] A = '0, B = '0, C;
    logic [46:0] qH = QH0;
    logic        err_o;

    int n_cmp = 0;
    int n_err = 0;

    logic [64:0] exp_q[$];
    logic [64:0] got_q[$];

    always #5 clk = ~clk;

    modsub #(
        .LOGA(LOGA), .LOGB(LOGB), .LOGQ(LOGQ), .LOGQH(LOGQH),
        .FF_IN(FF_IN), .FF_SUB(FF_SUB), .FF_OUT(FF_OUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .qH(qH),
        .out_valid(out_valid), .out_ready(out_ready),
        .C(C)
`ifdef MODSUB_RANGE_CHK_EN
        , .err(err_o)
`endif
    );
`ifndef MODSUB_RANGE_CHK_EN
    assign err_o = 1'b0;
`endif

    function automatic logic [63:0] qof(input logic [46:0] qh);
        return {qh, 16'h0000, 1'b1};
    endfunction

    // reference: (a - b) mod q for in-range operands; the same borrow rule otherwise
    function automatic logic [64:0] ref_out(input logic [63:0] a, input logic [63:0] b,
                                            input logic [46:0] qh);
        logic [63:0] q;
        logic [63:0] c;
        logic        e;
        q = qof(qh);
        if (a >= b) c = a - b;
        else        c = a + q - b;
`ifdef MODSUB_RANGE_CHK_EN
        e = (a >= q) || (b >= q);
`else
        e = 1'b0;
`endif
        return {e, c};
    endfunction

    function automatic logic [63:0] rnd_below(input logic [63:0] q);
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r % q;
    endfunction

    // transfer recorder: inputs and outputs that complete at the next edge
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready)   exp_q.push_back(ref_out(A, B, qH));
            if (out_valid && out_ready) got_q.push_back({err_o, C});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_vectors();
        logic [63:0] va[4];
        logic [63:0] vb[4];
        logic [63:0] vc[4];
        va[0] = 64'h1000000000000005; vb[0] = 64'h010000000000000A; vc[0] = 64'h0EFFFFFFFFFFFFFB;
        va[1] = 64'h010000000000000A; vb[1] = 64'h1000000000000005; vc[1] = 64'h7100118000000006;
        va[2] = 64'h0123456789ABCDEF; vb[2] = 64'h0123456789ABCDEF; vc[2] = 64'h0;
        va[3] = 64'h0;                vb[3] = 64'h1;                vc[3] = 64'h8000118000000000;
        out_ready = 1'b1; qH = QH0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; A = va[i]; B = vb[i];
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++; $display("FAIL vec%0d_in_ready: got %b expected 1", i, in_ready);
            end
            step();
            in_valid = 1'b0;
            for (int k = 1; k < LAT; k++) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_err++; $display("FAIL vec%0d_early_valid: cycle %0d got %b expected 0", i, k, out_valid);
                end
                step();
            end
            n_cmp++;
            if (out_valid !== 1'b1) begin
                n_err++; $display("FAIL vec%0d_latency: got out_valid %b expected 1", i, out_valid);
            end
            n_cmp++;
            if (C !== vc[i]) begin
                n_err++; $display("FAIL vec%0d_C: got %h expected %h", i, C, vc[i]);
            end
            step();
        end
    endtask

    task automatic test_back_to_back();
        int          sent = 0;
        int          cyc = 0;
        int          hold = 0;
        int          n;
        bit          seen = 1'b0;
        bit          acc;
        logic [63:0] q;
        q = qof(QH0);
        exp_q.delete(); got_q.delete();
        out_ready = 1'b1; qH = QH0;
        in_valid = 1'b1; A = rnd_below(q); B = rnd_below(q);
        while (got_q.size() < 4 && cyc < 200) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            if (!out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++; $display("FAIL stall_in_ready: got %b expected 0", in_ready);
                end
                n_cmp++;
                if (out_valid !== 1'b1 || {err_o, C} !== exp_q[0]) begin
                    n_err++; $display("FAIL stall_hold: got v=%b C=%h expected v=1 C=%h",
                                      out_valid, C, exp_q[0][63:0]);
                end
            end
            @(posedge clk); #1; cyc++;
            if (acc) begin
                sent++;
                if (sent < 4) begin A = rnd_below(q); B = rnd_below(q); end
                else in_valid = 1'b0;
            end
            if (!seen && out_valid) begin
                seen = 1'b1; out_ready = 1'b0; hold = 5;
            end else if (hold > 0) begin
                hold--;
                if (hold == 0) out_ready = 1'b1;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + 3) step();
        n_cmp++;
        if (got_q.size() != 4 || exp_q.size() != 4) begin
            n_err++; $display("FAIL b2b_count: got %0d outputs from %0d inputs expected 4/4",
                              got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL b2b_data%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int          n;
        int          sel;
        logic [63:0] q;
        exp_q.delete(); got_q.delete();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            qH        = 47'({$urandom, $urandom});
            q         = qof(qH);
            sel       = $urandom_range(0, 15);
            case (sel)
                0:       begin A = q - 64'd1; B = 64'd0; end
                1:       begin A = 64'd0;     B = q - 64'd1; end
                2:       begin A = rnd_below(q); B = A; end
                3:       begin A = {$urandom, $urandom}; B = {$urandom, $urandom}; end
                default: begin A = rnd_below(q); B = rnd_below(q); end
            endcase
            @(negedge clk);
            n_cmp++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                n_err++; $display("FAIL rnd_in_ready: cycle %0d got %b expected %b",
                                  cyc, in_ready, !(out_valid && !out_ready));
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (LAT + 4) step();
        n_cmp++;
        if (got_q.size() != exp_q.size()) begin
            n_err++; $display("FAIL rnd_count: got %0d outputs expected %0d", got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_cmp++;
            if (got_q[i] !== exp_q[i]) begin
                n_err++; $display("FAIL rnd_data%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_flight();
        int          k = 0;
        int          stale = 0;
        logic [63:0] q;
        logic [64:0] e;
        q = qof(QH0);
        exp_q.delete(); got_q.delete();
        qH = QH0; out_ready = 1'b0;
        in_valid = 1'b1; A = rnd_below(q); B = rnd_below(q);
        step();
        A = rnd_below(q); B = rnd_below(q);
        step();
        in_valid = 1'b0;
        while (!out_valid && k < 20) begin step(); k++; end
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("FAIL flight_setup: got out_valid %b expected 1", out_valid);
        end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++; $display("FAIL async_reset_valid: got %b expected 0", out_valid);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_err++; $display("FAIL async_reset_ready: got %b expected 1", in_ready);
        end
        step(); step();
        rst_n = 1'b1; out_ready = 1'b1;
        exp_q.delete(); got_q.delete();
        for (int i = 0; i < 10; i++) begin
            step();
            if (out_valid !== 1'b0) stale++;
        end
        n_cmp++;
        if (stale != 0) begin
            n_err++; $display("FAIL stale_after_reset: got %0d valid cycles expected 0", stale);
        end
        in_valid = 1'b1; A = rnd_below(q); B = rnd_below(q);
        e = ref_out(A, B, QH0);
        step();
        in_valid = 1'b0;
        for (int i = 1; i < LAT; i++) step();
        n_cmp++;
        if (out_valid !== 1'b1 || {err_o, C} !== e) begin
            n_err++; $display("FAIL post_reset_txn: got v=%b C=%h expected v=1 C=%h", out_valid, C, e[63:0]);
        end
        step();
    endtask

`ifdef MODSUB_RANGE_CHK_EN
    task automatic test_range_chk();
        logic [63:0] va[2];
        logic [63:0] vb[2];
        logic [63:0] vc[2];
        logic        ve[2];
        va[0] = 64'h8000118000000001; vb[0] = 64'h0; vc[0] = 64'h8000118000000001; ve[0] = 1'b1;
        va[1] = 64'd5;                vb[1] = 64'd3; vc[1] = 64'd2;                ve[1] = 1'b0;
        out_ready = 1'b1; qH = QH0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; A = va[i]; B = vb[i];
            step();
            in_valid = 1'b0;
            for (int k = 1; k < LAT; k++) step();
            n_cmp++;
            if (out_valid !== 1'b1 || err_o !== ve[i] || C !== vc[i]) begin
                n_err++; $display("FAIL range%0d: got v=%b err=%b C=%h expected v=1 err=%b C=%h",
                                  i, out_valid, err_o, C, ve[i], vc[i]);
            end
            step();
        end
    endtask
`endif

    initial begin
        test_reset();
        test_vectors();
        test_back_to_back();
        test_random();
        test_reset_flight();
`ifdef MODSUB_RANGE_CHK_EN
        test_range_chk();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
